// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: redirect input, instruction-memory request/response, decode-side handshake.
// o_misaligned exists only when FETCH_MISALIGN_CHECK_EN is defined.
interface fetch_stage_if;
  import core_pkg::*;

  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req_valid;
  logic            i_imem_req_ready;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_resp_valid;
  logic [XLEN-1:0] i_imem_resp_data;
  logic            o_inst_valid;
  logic            i_inst_ready;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            o_misaligned;
`endif

  modport master (
    input  i_redirect_valid, i_redirect_pc, i_imem_req_ready, i_imem_resp_valid,
           i_imem_resp_data, i_inst_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
    output o_misaligned,
`endif
    output o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_pc
  );

  modport slave (
    output i_redirect_valid, i_redirect_pc, i_imem_req_ready, i_imem_resp_valid,
           i_imem_resp_data, i_inst_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
    input  o_misaligned,
`endif
    input  o_imem_req_valid, o_imem_addr, o_inst_valid, o_inst, o_pc
  );
endinterface

// File: rtl/fetch_stage_fifo.sv
// Synchronous FIFO of fetch entries; a flush with a simultaneous push leaves exactly that entry.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t wdata_i,
  output fetch_entry_t rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o
);
  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rptr_q <= '0;
      if (push_i) begin
        mem_q[0] <= wdata_i;
        wptr_q   <= AW'(1);
        count_q  <= CW'(1);
      end else begin
        wptr_q  <= '0;
        count_q <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, in-order imem requests, response buffering and redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned redirect targets into a single NOP entry.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input logic           i_clk,
  input logic           i_rst,
  fetch_stage_if.master fif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;
  fetch_entry_t    hold_q;

  logic            redirect, resp, resp_keep, req_fire, inst_pop, stall;
  logic [XLEN-1:0] target;
  logic            target_mis;
  logic [CW:0]     outstanding, occupancy;

  fetch_entry_t    pcq_wdata, pcq_head, ififo_wdata, ififo_head;
  logic [CW-1:0]   pcq_count, ififo_count;
  logic            pcq_full, pcq_empty, ififo_full, ififo_empty, ififo_push;
  logic            unused_ok;

  assign redirect  = fif.i_redirect_valid;
  assign resp      = fif.i_imem_resp_valid;
  assign resp_keep = resp && (drop_q == '0) && !pcq_empty;

  // Requests still owed a response are those awaiting a PC plus those already condemned.
  assign outstanding = {1'b0, drop_q} + {1'b0, pcq_count};
  assign occupancy   = outstanding + {1'b0, ififo_count};

`ifdef FETCH_MISALIGN_CHECK_EN
  logic stall_q, stall_d;
  assign target     = fif.i_redirect_pc;
  assign target_mis = |target[1:0];
  assign stall      = stall_q;
  assign stall_d    = redirect ? target_mis : stall_q;
  assign fif.o_misaligned = !ififo_empty && (|ififo_head.pc[1:0]);
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) stall_q <= 1'b0;
    else       stall_q <= stall_d;
  end
  assign unused_ok = ^{pcq_head.inst, pcq_full, ififo_full};
`else
  assign target     = {fif.i_redirect_pc[XLEN-1:2], 2'b00};
  assign target_mis = 1'b0;
  assign stall      = 1'b0;
  assign unused_ok  = ^{pcq_head.inst, pcq_full, ififo_full, fif.i_redirect_pc[1:0]};
`endif

  assign fif.o_imem_req_valid = !i_rst && !redirect && !stall && (occupancy < DEPTH_W);
  assign fif.o_imem_addr      = pc_q;
  assign req_fire             = fif.o_imem_req_valid && fif.i_imem_req_ready;

  assign fif.o_inst_valid = !ififo_empty;
  assign inst_pop         = !ififo_empty && fif.i_inst_ready && !redirect;
  assign fif.o_inst       = ififo_empty ? hold_q.inst : ififo_head.inst;
  assign fif.o_pc         = ififo_empty ? hold_q.pc   : ififo_head.pc;

  assign ififo_push = redirect ? target_mis : resp_keep;
  assign pcq_wdata  = '{inst: {XLEN{1'b0}}, pc: pc_q};

  always_comb begin
    ififo_wdata = '{inst: fif.i_imem_resp_data, pc: pcq_head.pc};
    if (redirect) ififo_wdata = '{inst: INST_NOP, pc: target};
  end

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d   = target;
      drop_d = CW'(outstanding - (CW+1)'(resp));
    end else begin
      if (req_fire) pc_d = pc_next(pc_q);
      if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
      hold_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
      if (!ififo_empty) hold_q <= ififo_head;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_pc_queue (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (req_fire),
    .pop_i   (resp_keep),
    .flush_i (redirect),
    .wdata_i (pcq_wdata),
    .rdata_o (pcq_head),
    .full_o  (pcq_full),
    .empty_o (pcq_empty),
    .count_o (pcq_count)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .push_i  (ififo_push),
    .pop_i   (inst_pop),
    .flush_i (redirect),
    .wdata_i (ififo_wdata),
    .rdata_o (ififo_head),
    .full_o  (ififo_full),
    .empty_o (ififo_empty),
    .count_o (ififo_count)
  );
endmodule
